data_mem_resp: RTL and testbench
================================

DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 16-bit words of storage (power of two).
REQ-002 SHALL have parameter LATENCY, default 4, meaning the clock edges from request acceptance to response (legal range 2..15).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  initiator presents a request this cycle.
REQ-006 req_wr  input  1  1 = write, 0 = read; qualified by req_valid.
REQ-007 req_addr  input  16  byte address; bit 0 ignored.
REQ-008 req_wdata  input  16  write data; qualified by req_valid && req_wr.
REQ-009 req_ready  output  1  responder accepts a request this cycle.
REQ-010 rsp_valid  output  1  response present; one-cycle pulse per accepted request.
REQ-011 rsp_wr  output  1  response type (echo of the accepted req_wr).
REQ-012 rsp_data  output  16  read data; for writes, echo of the written data.
REQ-013 busy  output  1  a request is outstanding (state WAIT).

Function
REQ-014 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-015 A request SHALL be accepted on a rising edge where req_valid && req_ready.
REQ-016 req_ready SHALL be 1 in IDLE and RESP, and 0 in WAIT.
REQ-017 On acceptance SHALL capture req_wr, the word index and req_wdata, load the counter with LATENCY-2, and go to WAIT.
REQ-018 Word index SHALL be req_addr[15:1] modulo DEPTH_WORDS; out-of-range addresses wrap silently.
REQ-019 In WAIT, the counter SHALL decrement each edge; on the edge where it equals 0, the FSM SHALL go to RESP.
REQ-020 rsp_valid SHALL be 1 exactly in RESP, i.e. during the cycle that follows the LATENCY-th edge after acceptance.
REQ-021 A write SHALL commit to storage on the edge entering RESP, never earlier.
REQ-022 Read data SHALL be sampled from storage on that same edge.
REQ-023 rsp_data and rsp_wr SHALL hold their value from RESP until the next RESP; rsp_data is don't-care-free (registered).
REQ-024 In RESP, a new request present SHALL be accepted (back-to-back, go to WAIT); otherwise the FSM SHALL go to IDLE.
REQ-025 A read accepted in the RESP cycle of a write to the same word SHALL return the newly written data.
REQ-026 req_valid while req_ready=0 SHALL be ignored: no capture, no queueing, and the initiator must hold it.
REQ-027 Sustained throughput SHALL be one request per LATENCY cycles.
REQ-028 busy SHALL equal (state == WAIT).

Reset
REQ-029 Asserting rst_n low SHALL immediately force state IDLE, counter 0, rsp_valid 0, rsp_wr 0, rsp_data 16'h0000, busy 0 and req_ready 1.
REQ-030 Reset mid-operation SHALL discard the outstanding request: no write commits and no response is produced.
REQ-031 Storage contents SHALL NOT be cleared by reset.

Structure
REQ-032 The shared package SHALL hold the state encoding, the default LATENCY and DEPTH_WORDS, and the 16-bit data and address width constants.
REQ-033 Storage SHALL be one sub-module, mem_array: single-port, synchronous write and registered read, with enable and wr inputs.
REQ-034 The FSM and counter SHALL live in data_mem_resp.

Verification
REQ-035 Reset, then read addr 16'h0010 after preloading word 8 with 16'hBEEF -> rsp_valid 4 cycles after acceptance, rsp_data = 16'hBEEF, rsp_wr = 0.
REQ-036 Write 16'h1234 to 16'h0020, then a back-to-back read of 16'h0021 accepted in the RESP cycle -> second response = 16'h1234, req_ready never high in WAIT.
REQ-037 req_valid held high continuously for 3 reads -> accepts exactly at cycles 0, 4 and 8; three single-cycle rsp_valid pulses at 4, 8 and 12.
REQ-038 Write 16'hAAAA to 16'h0040, then assert rst_n low 2 cycles after acceptance -> no rsp_valid; a subsequent read of 16'h0040 returns the prior contents.
REQ-039 With DEPTH_WORDS = 1024, write 16'h5A5A to 16'h0802 and read 16'h0002 -> returns 16'h5A5A (wrap).
REQ-040 With LATENCY = 2, a single read -> rsp_valid in the cycle after the 2nd edge, then IDLE.

Source files
------------

// File: rtl/data_mem_resp_pkg.sv
// data_mem_resp_pkg: shared widths, default parameters and FSM state encoding
package data_mem_resp_pkg;
    localparam int DATA_W          = 16;
    localparam int ADDR_W          = 16;
    localparam int DEF_LATENCY     = 4;
    localparam int DEF_DEPTH_WORDS = 1024;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;
endpackage

// File: rtl/data_mem_resp_mem_array.sv
// mem_array: single-port word storage, synchronous write, registered read
//   clk       rising-edge clock
//   rst_n     async active-low reset (clears the read register only, never the storage)
//   en_i      access strobe
//   wr_i      1 = write, 0 = read
//   addr_i    word index
//   wdata_i   write data
//   rdata_o   registered read data; on a write it echoes the written word
module mem_array
    import data_mem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int IW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              wr_i,
    input  logic [IW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk)
        if (en_i && wr_i) mem_q[addr_i] <= wdata_i;

    // the response register holds until the next access, so it doubles as the held rsp_data
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rdata_q <= '0;
        else if (en_i) rdata_q <= wr_i ? wdata_i : mem_q[addr_i];

    assign rdata_o = rdata_q;
endmodule

// File: rtl/data_mem_resp.sv
// data_mem_resp: fixed-latency request/response memory responder
//   clk, rst_n            clock, async active-low reset
//   req_valid/req_ready   request handshake; accepted when both high on a rising edge
//   req_wr, req_addr      request type and byte address (bit 0 ignored, word index wraps)
//   req_wdata             write data
//   rsp_valid             one-cycle pulse LATENCY edges after acceptance
//   rsp_wr, rsp_data      response type and data, held until the next response
//   busy                  a request is outstanding
module data_mem_resp
    import data_mem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int LATENCY     = DEF_LATENCY
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic              rsp_wr,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy
);
    localparam int IW = $clog2(DEPTH_WORDS);

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic              wr_q, rsp_valid_q, rsp_wr_q, busy_q, ready_q;
    logic [IW-1:0]     idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic [ADDR_W-2:0] word;
    logic              mem_en;
    logic              unused_addr;

    assign word        = req_addr[ADDR_W-1:1];
    assign unused_addr = ^{req_addr[0], word};
    // the storage access happens on exactly the edge that enters RESP
    assign mem_en      = (state_q == WAIT) && (cnt_q == 4'd0);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            wr_q        <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_wr_q    <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            case (state_q)
                IDLE, RESP: begin
                    rsp_valid_q <= 1'b0;
                    if (req_valid) begin
                        state_q <= WAIT;
                        wr_q    <= req_wr;
                        idx_q   <= word[IW-1:0];
                        wdata_q <= req_wdata;
                        cnt_q   <= 4'(LATENCY - 2);
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_wr_q    <= wr_q;
                        busy_q      <= 1'b0;
                        ready_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    ready_q     <= 1'b1;
                end
            endcase
        end

    mem_array #(.DEPTH_WORDS(DEPTH_WORDS), .IW(IW)) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (mem_en),
        .wr_i    (wr_q),
        .addr_i  (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (rsp_data)
    );

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_wr    = rsp_wr_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_data_mem_resp.sv
// tb_data_mem_resp: directed and random checks of data_mem_resp against a word-array model
module tb_data_mem_resp;
    localparam int LAT   = 4;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_wr, req_ready, rsp_valid, rsp_wr, busy;
    logic [15:0] req_addr, req_wdata, rsp_data;
    logic        b_req_valid, b_req_wr, b_req_ready, b_rsp_valid, b_rsp_wr, b_busy;
    logic [15:0] b_req_addr, b_req_wdata, b_rsp_data;

    logic [15:0] mem_m [DEPTH];
    bit          known [DEPTH];
    int          n_chk  = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    data_mem_resp #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_wr(rsp_wr), .rsp_data(rsp_data), .busy(busy)
    );

    data_mem_resp #(.DEPTH_WORDS(64), .LATENCY(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_wr(b_req_wr),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_ready(b_req_ready),
        .rsp_valid(b_rsp_valid), .rsp_wr(b_rsp_wr), .rsp_data(b_rsp_data), .busy(b_busy)
    );

    function automatic int widx(input logic [15:0] a);
        return (int'(a) / 2) % DEPTH;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from a cycle where it may be presented; returns in the response cycle.
    task automatic issue(input logic wr, input logic [15:0] addr, input logic [15:0] wd);
        int          n;
        logic [15:0] exp;
        exp       = wr ? wd : mem_m[widx(addr)];
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wd;
        n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        check("accept_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 20) begin
            check("wait_ready", req_ready, 0);
            check("wait_busy", busy, 1);
            tick();
            n++;
        end
        check("latency", 16'(n), 16'(LAT));
        check("rsp_wr", rsp_wr, wr);
        check("rsp_data", rsp_data, exp);
        check("resp_busy", busy, 0);
        check("resp_ready", req_ready, 1);
        if (wr) begin
            mem_m[widx(addr)] = wd;
            known[widx(addr)] = 1'b1;
        end
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            tick();
            check("idle_rspv", rsp_valid, 0);
            check("idle_busy", busy, 0);
            check("idle_ready", req_ready, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        {req_valid, req_wr, req_addr, req_wdata} = '0;
        {b_req_valid, b_req_wr, b_req_addr, b_req_wdata} = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rspv", rsp_valid, 0);
        check("rst_rspwr", rsp_wr, 0);
        check("rst_data", rsp_data, 16'h0000);
        check("rst_busy", busy, 0);
        check("rst_ready", req_ready, 1);
        rst_n = 1'b1;
        tick();

        // preload word 8, read it back through byte address 0x0010
        issue(1'b1, 16'h0010, 16'hBEEF);
        idle(1);
        issue(1'b0, 16'h0010, 16'h0000);
        check("beef", rsp_data, 16'hBEEF);

        // write then back-to-back read of the same word from the RESP cycle
        issue(1'b1, 16'h0020, 16'h1234);
        issue(1'b0, 16'h0021, 16'h0000);
        check("b2b", rsp_data, 16'h1234);
        idle(1);

        // req_valid held for three reads: accepts at 0,4,8 and pulses at 4,8,12
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_addr  = 16'h0010;
        for (int c = 0; c <= 12; c++) begin
            check("hold_ready", req_ready, 16'(c % 4 == 0));
            check("hold_rspv", rsp_valid, 16'(c != 0 && c % 4 == 0));
            if (c != 0 && c % 4 == 0) check("hold_data", rsp_data, mem_m[widx(16'h0010)]);
            if (c == 9) req_valid = 1'b0;
            if (c < 12) tick();
        end
        idle(1);

        // reset two cycles into a write discards it; storage keeps the old word
        issue(1'b1, 16'h0040, 16'h7777);
        idle(1);
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_addr  = 16'h0040;
        req_wdata = 16'hAAAA;
        tick();
        req_valid = 1'b0;
        tick();
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("arst_rspv", rsp_valid, 0);
        check("arst_rspwr", rsp_wr, 0);
        check("arst_data", rsp_data, 16'h0000);
        check("arst_busy", busy, 0);
        check("arst_ready", req_ready, 1);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("post_rst_rspv", rsp_valid, 0);
        end
        issue(1'b0, 16'h0040, 16'h0000);
        check("rst_keep", rsp_data, 16'h7777);

        // address wrap at 1024 words
        issue(1'b1, 16'h0802, 16'h5A5A);
        issue(1'b0, 16'h0002, 16'h0000);
        check("wrap", rsp_data, 16'h5A5A);

        // random traffic over aliased addresses with random idle gaps
        for (int i = 0; i < 60; i++) begin
            int          w;
            logic [15:0] a;
            logic        wr;
            w  = $urandom_range(0, 15);
            a  = 16'((($urandom_range(0, 31) * DEPTH + w) * 2) + $urandom_range(0, 1));
            wr = !known[widx(a)] || ($urandom_range(0, 1) == 1);
            issue(wr, a, 16'($urandom));
            idle($urandom_range(0, 2));
        end

        // LATENCY = 2 instance: a write, then a read of the same word
        for (int k = 0; k < 2; k++) begin
            b_req_valid = 1'b1;
            b_req_wr    = (k == 0);
            b_req_addr  = 16'h0006;
            b_req_wdata = (k == 0) ? 16'hC3C3 : 16'h0000;
            check("l2_ready", b_req_ready, 1);
            tick();
            b_req_valid = 1'b0;
            check("l2_c1_rspv", b_rsp_valid, 0);
            check("l2_c1_busy", b_busy, 1);
            tick();
            check("l2_c2_rspv", b_rsp_valid, 1);
            check("l2_c2_wr", b_rsp_wr, 16'(k == 0));
            check("l2_c2_data", b_rsp_data, 16'hC3C3);
            tick();
            check("l2_idle_rspv", b_rsp_valid, 0);
            check("l2_idle_busy", b_busy, 0);
            check("l2_idle_ready", b_req_ready, 1);
            check("l2_hold_data", b_rsp_data, 16'hC3C3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
